// File: rtl/clock_pkg.sv
// Shared definitions for the alarm-clock key controller: FSM state codes,
// the idle key code, BCD limits and the HH:MM validity check.
package clock_pkg;

    // FSM state codes.
    typedef logic [2:0] state_t;

    localparam state_t SHOW_TIME  = 3'd0;
    localparam state_t KEY_STORED = 3'd1;
    localparam state_t KEY_WAITED = 3'd2;
    localparam state_t KEY_ENTRY  = 3'd3;
    localparam state_t SHOW_ALARM = 3'd4;

    // Key code reported by the scanner when no key is pressed.
    localparam logic [3:0] NOKEY = 4'hA;

    // BCD limits for a 24-hour HH:MM value.
    localparam logic [3:0] BCD_DIGIT_MAX   = 4'd9;
    localparam logic [3:0] BCD_MS_HR_MAX   = 4'd2;
    localparam logic [3:0] BCD_LS_HR_AT_20 = 4'd3;
    localparam logic [3:0] BCD_MS_MIN_MAX  = 4'd5;

    // True for a decimal digit key (0-9).
    function automatic logic is_digit(input logic [3:0] k);
        return (k <= BCD_DIGIT_MAX);
    endfunction

    // True when {ms_hr, ls_hr, ms_min, ls_min} is a legal 24-hour time.
    function automatic logic hhmm_valid(input logic [15:0] t);
        logic ok;
        ok = (t[15:12] <= BCD_MS_HR_MAX)  &&
             (t[11:8]  <= BCD_DIGIT_MAX)  &&
             (t[7:4]   <= BCD_MS_MIN_MAX) &&
             (t[3:0]   <= BCD_DIGIT_MAX);
        if ((t[15:12] == BCD_MS_HR_MAX) && (t[11:8] > BCD_LS_HR_AT_20)) begin
            ok = 1'b0;
        end else begin
            ok = ok;
        end
        return ok;
    endfunction

endpackage

// File: rtl/clock_key_controller_if.sv
// Keypad/button inputs and counter/alarm/display outputs of the key controller.
interface clock_key_controller_if;

    logic [3:0]  key;
    logic        alarm_button;
    logic        time_button;
    logic [15:0] new_time;
    logic        load_new_c;
    logic        load_new_a;
    logic        show_alarm;
    logic        show_new_time;
    logic        entry_error;

    // Controller side.
    modport slave (
        input  key, alarm_button, time_button,
        output new_time, load_new_c, load_new_a, show_alarm, show_new_time, entry_error
    );

    // Keypad scanner / counter / display side.
    modport master (
        output key, alarm_button, time_button,
        input  new_time, load_new_c, load_new_a, show_alarm, show_new_time, entry_error
    );

endinterface

// File: rtl/key_buffer.sv
// Four-digit BCD entry buffer. The first digit of an entry clears the older
// digits; later digits shift in from the right, dropping the oldest digit.
module key_buffer
    import clock_pkg::*;
(
    input  logic        clock,
    input  logic        reset_n,
    input  logic        shift_en,
    input  logic        first,
    input  logic [3:0]  digit,
    output logic [15:0] value,
    output logic        valid
);

    // Shift register holding {ms_hr, ls_hr, ms_min, ls_min}.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            value <= 16'h0000;
        end else if (shift_en) begin
            if (first) begin
                value <= {12'h000, digit};
            end else begin
                value <= {value[11:0], digit};
            end
        end else begin
            value <= value;
        end
    end

    assign valid = hhmm_valid(value);

endmodule

// File: rtl/clock_key_controller.sv
// Keypad sequencer for the 24-hour alarm clock: collects digits into the BCD
// entry buffer, validates HH:MM on commit and strobes the counter or alarm
// register. Abandons an idle entry after TIMEOUT cycles.
module clock_key_controller
    import clock_pkg::*;
#(
    parameter int unsigned TIMEOUT = 2000,
    parameter int unsigned TW      = 11
) (
    input  logic                  clock,
    input  logic                  reset_n,
    clock_key_controller_if.slave bus
);

    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

    state_t        state;
    state_t        next_state;
    logic [3:0]    key_norm;
    logic [3:0]    key_prev;
    logic          digit_in;
    logic [TW-1:0] tcnt;
    logic          timeout_hit;
    logic          shift_en;
    logic          shift_first;
    logic          commit_c;
    logic          commit_a;
    logic          commit_err;
    logic [15:0]   buf_value;
    logic          buf_valid;
    logic          load_c;
    logic          load_a;
    logic          err_strobe;
    logic          alarm_disp;
    logic          entry_disp;

    key_buffer u_key_buffer (
        .clock    (clock),
        .reset_n  (reset_n),
        .shift_en (shift_en),
        .first    (shift_first),
        .digit    (key_norm),
        .value    (buf_value),
        .valid    (buf_valid)
    );

    // Map non-digit codes onto NOKEY and flag an expired idle timer.
    always_comb begin
        key_norm = NOKEY;
        if (is_digit(bus.key)) begin
            key_norm = bus.key;
        end else begin
            key_norm = NOKEY;
        end
        digit_in    = (key_norm != NOKEY);
        timeout_hit = (tcnt == TMAX);
    end

    // Next-state, buffer-shift and commit decisions.
    always_comb begin
        next_state  = state;
        shift_en    = 1'b0;
        shift_first = 1'b0;
        commit_c    = 1'b0;
        commit_a    = 1'b0;
        commit_err  = 1'b0;
        case (state)
            SHOW_TIME: begin
                if (digit_in) begin
                    shift_en    = 1'b1;
                    shift_first = 1'b1;
                    next_state  = KEY_STORED;
                end else if (bus.alarm_button) begin
                    next_state = SHOW_ALARM;
                end else begin
                    next_state = SHOW_TIME;
                end
            end
            KEY_STORED: begin
                next_state = KEY_WAITED;
            end
            KEY_WAITED: begin
                if (!digit_in) begin
                    next_state = KEY_ENTRY;
                end else if (timeout_hit) begin
                    next_state = SHOW_TIME;
                end else begin
                    next_state = KEY_WAITED;
                end
            end
            KEY_ENTRY: begin
                if (bus.time_button) begin
                    commit_c   = buf_valid;
                    commit_err = !buf_valid;
                    next_state = SHOW_TIME;
                end else if (bus.alarm_button) begin
                    commit_a   = buf_valid;
                    commit_err = !buf_valid;
                    next_state = SHOW_TIME;
                end else if (digit_in) begin
                    shift_en   = 1'b1;
                    next_state = KEY_STORED;
                end else if (timeout_hit) begin
                    next_state = SHOW_TIME;
                end else begin
                    next_state = KEY_ENTRY;
                end
            end
            SHOW_ALARM: begin
                if (!bus.alarm_button) begin
                    next_state = SHOW_TIME;
                end else begin
                    next_state = SHOW_ALARM;
                end
            end
            default: begin
                next_state = SHOW_TIME;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= SHOW_TIME;
        end else begin
            state <= next_state;
        end
    end

    // Remember the last sampled key so a changed key restarts the idle timer.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            key_prev <= NOKEY;
        end else begin
            key_prev <= key_norm;
        end
    end

    // Idle timer: restarts on any state change or key change, counts while
    // waiting for release or for the next digit, and saturates at TMAX.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tcnt <= '0;
        end else if ((next_state != state) || (key_norm != key_prev)) begin
            tcnt <= '0;
        end else if (((state == KEY_WAITED) || (state == KEY_ENTRY)) && (tcnt != TMAX)) begin
            tcnt <= tcnt + TW'(1);
        end else begin
            tcnt <= tcnt;
        end
    end

    // Registered strobes and display selects, aligned with the state register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            load_c     <= 1'b0;
            load_a     <= 1'b0;
            err_strobe <= 1'b0;
            alarm_disp <= 1'b0;
            entry_disp <= 1'b0;
        end else begin
            load_c     <= commit_c;
            load_a     <= commit_a;
            err_strobe <= commit_err;
            alarm_disp <= (next_state == SHOW_ALARM);
            entry_disp <= (next_state == KEY_STORED) ||
                          (next_state == KEY_WAITED) ||
                          (next_state == KEY_ENTRY);
        end
    end

    assign bus.new_time      = buf_value;
    assign bus.load_new_c    = load_c;
    assign bus.load_new_a    = load_a;
    assign bus.entry_error   = err_strobe;
    assign bus.show_alarm    = alarm_disp;
    assign bus.show_new_time = entry_disp;

endmodule

// File: tb/tb_clock_key_controller.sv
// Self-checking bench for clock_key_controller: a digit-queue model of the
// keypad rules is compared against the DUT every cycle, plus literal checks.
module tb_clock_key_controller;

    localparam int         TIMEOUT = 2000;
    localparam logic [3:0] NK      = 4'hA;

    logic clock = 1'b0;
    logic reset_n;

    clock_key_controller_if bus();

    clock_key_controller #(.TIMEOUT(TIMEOUT), .TW(11)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;
    int cnt_c = 0, cnt_a = 0, cnt_e = 0;
    int c0, a0, e0;

    // Model: mode 0 time display, 1 digit just stored, 2 waiting release,
    // 3 waiting next digit/commit, 4 alarm display.
    int  m_mode;
    int  dig[$];
    bit  e_c, e_a, e_err;
    int  m_edge, m_last;
    logic [3:0] m_prevk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] model_time();
        int v = 0;
        foreach (dig[i]) v = v * 16 + dig[i];
        return v[15:0];
    endfunction

    function automatic bit model_valid();
        logic [15:0] t;
        int h, m;
        t = model_time();
        h = t[15:12] * 10 + t[11:8];
        m = t[7:4] * 10 + t[3:0];
        return (h < 24) && (m < 60);
    endfunction

    task automatic model_reset();
        m_mode = 0; dig.delete(); e_c = 0; e_a = 0; e_err = 0;
        m_edge = 0; m_last = 0; m_prevk = NK;
    endtask

    task automatic model_step();
        logic [3:0] nk;
        bit d, tmo;
        int old;
        nk = (bus.key <= 4'd9) ? bus.key : NK;
        d = (nk != NK);
        m_edge++;
        tmo = ((m_edge - m_last) == TIMEOUT);
        old = m_mode;
        e_c = 0; e_a = 0; e_err = 0;
        case (m_mode)
            0: if (d) begin dig.delete(); dig.push_back(int'(nk)); m_mode = 1; end
               else if (bus.alarm_button) m_mode = 4;
            1: m_mode = 2;
            2: if (!d) m_mode = 3; else if (tmo) m_mode = 0;
            3: if (bus.time_button || bus.alarm_button) begin
                   if (!model_valid()) e_err = 1;
                   else if (bus.time_button) e_c = 1;
                   else e_a = 1;
                   m_mode = 0;
               end else if (d) begin
                   dig.push_back(int'(nk));
                   if (dig.size() > 4) void'(dig.pop_front());
                   m_mode = 1;
               end else if (tmo) m_mode = 0;
            4: if (!bus.alarm_button) m_mode = 0;
            default: m_mode = 0;
        endcase
        if ((m_mode != old) || (nk != m_prevk)) m_last = m_edge;
        m_prevk = nk;
    endtask

    // One clock: the model consumes exactly what the DUT sampled at the edge.
    task automatic cyc();
        @(posedge clock);
        if (reset_n) model_step(); else model_reset();
        #2;
    endtask

    task automatic press(input logic [3:0] k, input int hold);
        bus.key = k;
        repeat (hold) cyc();
        bus.key = NK;
        repeat (2) cyc();
    endtask

    task automatic commit(input bit tb, input bit ab);
        bus.time_button = tb; bus.alarm_button = ab;
        cyc();
        bus.time_button = 1'b0; bus.alarm_button = 1'b0;
    endtask

    task automatic snap();
        c0 = cnt_c; a0 = cnt_a; e0 = cnt_e;
    endtask

    // Per-cycle comparison against the model, plus strobe pulse counting.
    initial begin
        forever begin
            @(negedge clock);
            chk("new_time",      {16'h0, bus.new_time},   {16'h0, model_time()});
            chk("load_new_c",    {31'h0, bus.load_new_c}, {31'h0, e_c});
            chk("load_new_a",    {31'h0, bus.load_new_a}, {31'h0, e_a});
            chk("entry_error",   {31'h0, bus.entry_error}, {31'h0, e_err});
            chk("show_new_time", {31'h0, bus.show_new_time}, {31'h0, (m_mode >= 1 && m_mode <= 3)});
            chk("show_alarm",    {31'h0, bus.show_alarm}, {31'h0, (m_mode == 4)});
            if (bus.load_new_c)  cnt_c++;
            if (bus.load_new_a)  cnt_a++;
            if (bus.entry_error) cnt_e++;
        end
    end

    initial begin
        bus.key = NK; bus.alarm_button = 1'b0; bus.time_button = 1'b0;
        reset_n = 1'b0;
        model_reset();
        repeat (3) cyc();
        chk("rst_new_time", bus.new_time, 16'h0000);
        chk("rst_strobes", {bus.load_new_c, bus.load_new_a, bus.entry_error}, 3'b000);
        chk("rst_display", {bus.show_alarm, bus.show_new_time}, 2'b00);
        reset_n = 1'b1;
        cyc();

        // Clock entry 12:34.
        snap();
        press(4'd1, 3); press(4'd2, 3); press(4'd3, 3); press(4'd4, 3);
        chk("model_pack_1234", model_time(), 16'h1234);
        commit(1, 0);
        chk("clk_load_c", bus.load_new_c, 1'b1);
        chk("clk_load_a", bus.load_new_a, 1'b0);
        chk("clk_value", bus.new_time, 16'h1234);
        repeat (2) cyc();
        chk("clk_pulses", cnt_c - c0, 1);
        chk("clk_back_show_time", bus.show_new_time, 1'b0);

        // Alarm entry 23:59.
        snap();
        press(4'd2, 3); press(4'd3, 3); press(4'd5, 3); press(4'd9, 3);
        commit(0, 1);
        chk("alm_load_a", bus.load_new_a, 1'b1);
        chk("alm_value", bus.new_time, 16'h2359);
        repeat (2) cyc();
        chk("alm_pulses_a", cnt_a - a0, 1);
        chk("alm_pulses_c", cnt_c - c0, 0);

        // Invalid entries 24:00 and 12:60.
        snap();
        press(4'd2, 3); press(4'd4, 3); press(4'd0, 3); press(4'd0, 3);
        chk("model_invalid_2400", model_valid(), 1'b0);
        commit(1, 0);
        chk("inv_err", bus.entry_error, 1'b1);
        chk("inv_no_load", bus.load_new_c, 1'b0);
        chk("inv_value", bus.new_time, 16'h2400);
        repeat (2) cyc();
        press(4'd1, 3); press(4'd2, 3); press(4'd6, 3); press(4'd0, 3);
        commit(1, 0);
        chk("inv2_err", bus.entry_error, 1'b1);
        chk("inv2_value", bus.new_time, 16'h1260);
        repeat (2) cyc();
        chk("inv_pulses", {cnt_e - e0, cnt_c - c0}, {32'd2, 32'd0});

        // Two digits give leading zeros; five digits drop the oldest.
        press(4'd4, 3); press(4'd5, 3);
        commit(1, 0);
        chk("short_load_c", bus.load_new_c, 1'b1);
        chk("short_value", bus.new_time, 16'h0045);
        repeat (2) cyc();
        press(4'd1, 3); press(4'd2, 3); press(4'd3, 3); press(4'd4, 3); press(4'd5, 3);
        commit(0, 1);
        chk("long_load_a", bus.load_new_a, 1'b1);
        chk("long_value", bus.new_time, 16'h2345);
        repeat (2) cyc();

        // Held key shifts once; then entry idles out exactly at TIMEOUT.
        snap();
        press(4'd7, 50);
        chk("held_value", bus.new_time, 16'h0007);
        repeat (TIMEOUT - 2) cyc();
        chk("idle_before_timeout", bus.show_new_time, 1'b1);
        cyc();
        chk("idle_after_timeout", bus.show_new_time, 1'b0);

        // Key held through the release wait also times out.
        press(4'd8, TIMEOUT + 2);
        chk("waited_timeout_disp", bus.show_new_time, 1'b0);
        chk("waited_timeout_value", bus.new_time, 16'h0008);
        chk("timeout_no_strobes", {cnt_c - c0, cnt_a - a0, cnt_e - e0}, 96'd0);

        // Alarm display while button held; keys ignored.
        bus.alarm_button = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk("show_alarm_held", bus.show_alarm, 1'b1);
            bus.key = 4'd3;
        end
        chk("show_alarm_keys_ignored", bus.new_time, 16'h0008);
        bus.alarm_button = 1'b0; bus.key = NK;
        cyc();
        chk("show_alarm_release", bus.show_alarm, 1'b0);

        // Both buttons: time commit wins.
        snap();
        press(4'd0, 3); press(4'd9, 3); press(4'd3, 3); press(4'd0, 3);
        commit(1, 1);
        chk("both_load_c", bus.load_new_c, 1'b1);
        chk("both_load_a", bus.load_new_a, 1'b0);
        chk("both_value", bus.new_time, 16'h0930);
        repeat (2) cyc();

        // Asynchronous reset drops a pending strobe mid-entry.
        press(4'd1, 3); press(4'd2, 3);
        bus.time_button = 1'b1;
        cyc();
        chk("pre_reset_strobe", bus.load_new_c, 1'b1);
        #1 reset_n = 1'b0;
        model_reset();
        #1;
        chk("async_rst_value", bus.new_time, 16'h0000);
        chk("async_rst_strobes", {bus.load_new_c, bus.load_new_a, bus.entry_error}, 3'b000);
        chk("async_rst_display", {bus.show_alarm, bus.show_new_time}, 2'b00);
        bus.time_button = 1'b0;
        repeat (2) cyc();
        reset_n = 1'b1;
        repeat (3) cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
